// File: rtl/voting_tally_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// voting_tally_ctrl_pkg
//   Shared definitions for the sequential voting tally controller.
//   CAND_W / VOTER_W : default candidate / voter index widths
//   NC / NV / TW     : candidate count, voter count, tally width
//   state_e          : controller state encoding
// ----------------------------------------------------------------------------
package voting_tally_ctrl_pkg;

  localparam int CAND_W  = 2;
  localparam int VOTER_W = 2;
  localparam int NC      = 2 ** CAND_W;
  localparam int NV      = 2 ** VOTER_W;
  localparam int TW      = VOTER_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_SCAN    = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/voting_tally_ctrl_tally_bank.sv
// ----------------------------------------------------------------------------
// tally_bank
//   2**N running counters of M+1 bits, one per candidate.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of every counter (wins over inc_en)
//   inc_en     : increment counter inc_idx this cycle
//   inc_idx    : counter to increment
//   rd_idx     : combinational read address (scan index)
//   rd_data    : value of counter rd_idx
// ----------------------------------------------------------------------------
module tally_bank
  import voting_tally_ctrl_pkg::*;
#(
  parameter int N = CAND_W,
  parameter int M = VOTER_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc_en,
  input  logic [N-1:0] inc_idx,
  input  logic [N-1:0] rd_idx,
  output logic [M:0]   rd_data
);

  localparam int NCAND = 1 << N;

  logic [M:0] tally_q [NCAND];
  logic [M:0] tally_d [NCAND];

  // No saturation: each voter is counted once, so a counter tops out at 2**M.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    tally_d = tally_q;
    if (clr) begin
      for (int i = 0; i < NCAND; i++) tally_d[i] = '0;
    end else if (inc_en) begin
      tally_d[inc_idx] = tally_q[inc_idx] + (M+1)'(1);
    end
  end

  // NOTE: the counters are a handful of flops, not a RAM macro, so they take
  // the async reset like any other state; the abort-on-reset behaviour needs it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCAND; i++) tally_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples the pre-edge values regardless of statement order.
      tally_q <= tally_d;
    end
  end

  assign rd_data = tally_q[rd_idx];

endmodule

// File: rtl/voting_tally_ctrl.sv
// ----------------------------------------------------------------------------
// voting_tally_ctrl
//   Collects one ballot per cycle over a valid/ready port, rejects repeat
//   voters, closes on request or when every voter has voted, then scans the
//   per-candidate tallies serially to find the winner (ties -> lowest index).
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : open a new poll (IDLE or DONE only)
//   close          : end collection early (COLLECT only)
//   vote_valid     : ballot present
//   vote_ready     : ballot accepted when high together with vote_valid
//   vote_voter     : voter id
//   vote_cand      : chosen candidate
//   dup_err        : registered one-cycle pulse after a repeat-voter handshake
//   busy           : high in COLLECT and SCAN
//   done           : high in DONE; winner / winner_count valid
//   winner         : winning candidate
//   winner_count   : tally of the winner
//   n_votes        : ballots counted in the current poll
// ----------------------------------------------------------------------------
module voting_tally_ctrl
  import voting_tally_ctrl_pkg::*;
#(
  parameter int N = CAND_W,
  parameter int M = VOTER_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         close,
  input  logic         vote_valid,
  output logic         vote_ready,
  input  logic [M-1:0] vote_voter,
  input  logic [N-1:0] vote_cand,
  output logic         dup_err,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] winner,
  output logic [M:0]   winner_count,
  output logic [M:0]   n_votes
);

  localparam int NCAND = 1 << N;
  localparam int NVOTE = 1 << M;

  localparam logic [N-1:0] LAST_IDX = N'(NCAND - 1);
  localparam logic [M:0]   ALL_VOTED = (M+1)'(NVOTE);

  state_e             state_q, state_d;
  logic [NVOTE-1:0]   bitmap_q, bitmap_d;
  logic [M:0]         n_votes_q, n_votes_d;
  logic [N-1:0]       winner_q, winner_d;
  logic [M:0]         winner_count_q, winner_count_d;
  logic [N-1:0]       scan_idx_q, scan_idx_d;
  logic [M:0]         max_q, max_d;
  logic [N-1:0]       best_q, best_d;
  logic               dup_err_q, dup_err_d;

  logic               bank_clr;
  logic               bank_inc;
  logic [N-1:0]       bank_inc_idx;
  logic [M:0]         bank_rd_data;

  logic [M:0]         cand_max;
  logic [N-1:0]       cand_best;
  logic [M:0]         n_votes_inc;

  tally_bank #(.N(N), .M(M)) u_tally_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (bank_clr),
    .inc_en  (bank_inc),
    .inc_idx (bank_inc_idx),
    .rd_idx  (scan_idx_q),
    .rd_data (bank_rd_data)
  );

  assign n_votes_inc = n_votes_q + (M+1)'(1);

  // Running max for the current scan step. Index 0 loads unconditionally;
  // later indices replace only on a strictly greater tally, so ties keep
  // the lower index.
  always_comb begin
    cand_max  = max_q;
    cand_best = best_q;
    if ((scan_idx_q == '0) || (bank_rd_data > max_q)) begin
      cand_max  = bank_rd_data;
      cand_best = scan_idx_q;
    end
  end

  always_comb begin
    state_d        = state_q;
    bitmap_d       = bitmap_q;
    n_votes_d      = n_votes_q;
    winner_d       = winner_q;
    winner_count_d = winner_count_q;
    scan_idx_d     = scan_idx_q;
    max_d          = max_q;
    best_d         = best_q;
    dup_err_d      = 1'b0;
    bank_clr       = 1'b0;
    bank_inc       = 1'b0;
    bank_inc_idx   = '0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d        = ST_COLLECT;
          bank_clr       = 1'b1;
          bitmap_d       = '0;
          n_votes_d      = '0;
          winner_d       = '0;
          winner_count_d = '0;
          scan_idx_d     = '0;
        end
      end

      ST_COLLECT: begin
        // Voter/candidate fields are only looked at under vote_valid, so
        // undriven values between ballots never reach any state.
        if (vote_valid) begin
          if (!bitmap_q[vote_voter]) begin
            bank_inc               = 1'b1;
            bank_inc_idx           = vote_cand;
            bitmap_d[vote_voter]   = 1'b1;
            n_votes_d              = n_votes_inc;
            if (n_votes_inc == ALL_VOTED) state_d = ST_SCAN;
          end else begin
            dup_err_d = 1'b1;
          end
        end
        if (close) state_d = ST_SCAN;
        if (state_d == ST_SCAN) scan_idx_d = '0;
      end

      ST_SCAN: begin
        max_d  = cand_max;
        best_d = cand_best;
        if (scan_idx_q == LAST_IDX) begin
          winner_d       = cand_best;
          winner_count_d = cand_max;
          state_d        = ST_DONE;
        end else begin
          scan_idx_d = scan_idx_q + N'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      bitmap_q       <= '0;
      n_votes_q      <= '0;
      winner_q       <= '0;
      winner_count_q <= '0;
      scan_idx_q     <= '0;
      max_q          <= '0;
      best_q         <= '0;
      dup_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      bitmap_q       <= bitmap_d;
      n_votes_q      <= n_votes_d;
      winner_q       <= winner_d;
      winner_count_q <= winner_count_d;
      scan_idx_q     <= scan_idx_d;
      max_q          <= max_d;
      best_q         <= best_d;
      dup_err_q      <= dup_err_d;
    end
  end

  assign vote_ready   = (state_q == ST_COLLECT);
  assign busy         = (state_q == ST_COLLECT) || (state_q == ST_SCAN);
  assign done         = (state_q == ST_DONE);
  assign dup_err      = dup_err_q;
  assign winner       = winner_q;
  assign winner_count = winner_count_q;
  assign n_votes      = n_votes_q;

endmodule

// File: tb/tb_voting_tally_ctrl.sv
// ----------------------------------------------------------------------------
// tb_voting_tally_ctrl
//   Directed polls for voting_tally_ctrl. The driver pushes the expected poll
//   result (and expected dup_err cycles) into queues; a monitor on the falling
//   edge pops and compares whenever done rises or dup_err pulses.
// ----------------------------------------------------------------------------
module tb_voting_tally_ctrl;

  typedef struct {
    int winner;
    int count;
    int nv;
    int done_cyc;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       close;
  logic       vote_valid;
  logic       vote_ready;
  logic [1:0] vote_voter;
  logic [1:0] vote_cand;
  logic       dup_err;
  logic       busy;
  logic       done;
  logic [1:0] winner;
  logic [2:0] winner_count;
  logic [2:0] n_votes;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  res_t res_q[$];
  int   dup_q[$];
  res_t mon_r;
  int   mon_dup;
  logic done_prev = 1'b0;

  voting_tally_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .close        (close),
    .vote_valid   (vote_valid),
    .vote_ready   (vote_ready),
    .vote_voter   (vote_voter),
    .vote_cand    (vote_cand),
    .dup_err      (dup_err),
    .busy         (busy),
    .done         (done),
    .winner       (winner),
    .winner_count (winner_count),
    .n_votes      (n_votes)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done && !done_prev) begin
        check("result_pending", 32'(res_q.size() != 0), 1);
        if (res_q.size() != 0) begin
          mon_r = res_q.pop_front();
          check("winner",       32'(winner),       mon_r.winner);
          check("winner_count", 32'(winner_count), mon_r.count);
          check("n_votes",      32'(n_votes),      mon_r.nv);
          check("done_cycle",   cyc,               mon_r.done_cyc);
        end
      end
      if (dup_err) begin
        check("dup_expected", 32'(dup_q.size() != 0), 1);
        if (dup_q.size() != 0) begin
          mon_dup = dup_q.pop_front();
          check("dup_cycle", cyc, mon_dup);
        end
      end
    end
    done_prev = done;
  end

  // ---------------------------------------------------------------- driver
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic cast(input int voter, input int cand, input bit with_close,
                      input bit is_dup, output int c);
    logic [31:0] v, k;
    v = voter;
    k = cand;
    vote_valid = 1'b1;
    vote_voter = v[1:0];
    vote_cand  = k[1:0];
    close      = with_close;
    c          = cyc;
    check("ready_in_collect", 32'(vote_ready), 1);
    if (is_dup) dup_q.push_back(c + 1);
    step();
    vote_valid = 1'b0;
    vote_voter = 'x;
    vote_cand  = 'x;
    close      = 1'b0;
  endtask

  task automatic do_close(output int c);
    close = 1'b1;
    c     = cyc;
    step();
    close = 1'b0;
  endtask

  task automatic expect_result(input int w, input int cnt, input int nv, input int c);
    res_t r;
    r.winner   = w;
    r.count    = cnt;
    r.nv       = nv;
    r.done_cyc = c + 5;
    res_q.push_back(r);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 20) begin
      step();
      n++;
    end
    check("done_within_budget", 32'(done), 1);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_busy"},       32'(busy),       0);
    check({tag, "_done"},       32'(done),       0);
    check({tag, "_n_votes"},    32'(n_votes),    0);
    check({tag, "_vote_ready"}, 32'(vote_ready), 0);
  endtask

  initial begin
    int c;
    rst_n      = 1'b0;
    start      = 1'b0;
    close      = 1'b0;
    vote_valid = 1'b0;
    vote_voter = 'x;
    vote_cand  = 'x;
    step();
    step();

    // Reset state
    reset_checks("reset");
    check("reset_dup_err",      32'(dup_err),      0);
    check("reset_winner",       32'(winner),       0);
    check("reset_winner_count", 32'(winner_count), 0);
    rst_n = 1'b1;
    step();

    // 1: four ballots, auto-close on the last one; c2 wins with 2
    do_start();
    check("busy_collect", 32'(busy), 1);
    cast(0, 2, 0, 0, c);
    cast(1, 2, 0, 0, c);
    cast(2, 1, 0, 0, c);
    cast(3, 3, 0, 0, c);
    expect_result(2, 2, 4, c);
    check("auto_close_ready", 32'(vote_ready), 0);
    wait_done();
    step();
    step();
    check("done_holds", 32'(done), 1);
    check("winner_holds", 32'(winner), 2);

    // 2: repeat voter discarded, tie c0/c3 resolves to c0
    do_start();
    cast(1, 0, 0, 0, c);
    cast(1, 3, 0, 1, c);
    cast(2, 3, 0, 0, c);
    do_close(c);
    expect_result(0, 1, 2, c);
    wait_done();

    // 3: close with no ballots
    do_start();
    do_close(c);
    expect_result(0, 0, 0, c);
    wait_done();

    // 4: ballot and close in the same cycle
    do_start();
    cast(0, 3, 1, 0, c);
    expect_result(3, 1, 1, c);
    wait_done();

    // 5a: reset during COLLECT after two ballots
    do_start();
    cast(0, 1, 0, 0, c);
    cast(1, 1, 0, 0, c);
    rst_n = 1'b0;
    #2;
    reset_checks("rst_collect");
    step();
    rst_n = 1'b1;
    step();

    // 5b: reset during SCAN
    do_start();
    cast(0, 2, 0, 0, c);
    cast(1, 2, 0, 0, c);
    do_close(c);
    step();
    check("busy_scan", 32'(busy), 1);
    rst_n = 1'b0;
    #2;
    reset_checks("rst_scan");
    step();
    rst_n = 1'b1;
    step();

    // 5c: full poll after reset; tie c0/c3 at 2 resolves to c0
    do_start();
    cast(0, 0, 0, 0, c);
    cast(1, 3, 0, 0, c);
    cast(2, 3, 0, 0, c);
    cast(3, 0, 0, 0, c);
    expect_result(0, 2, 4, c);
    wait_done();

    // 6: back-to-back poll, c1 only; ballots offered during SCAN are refused
    do_start();
    cast(2, 1, 0, 0, c);
    cast(0, 1, 0, 0, c);
    do_close(c);
    expect_result(1, 2, 2, c);
    vote_valid = 1'b1;
    vote_voter = 2'd3;
    vote_cand  = 2'd2;
    for (int i = 0; i < 4; i++) begin
      check("scan_ready_low", 32'(vote_ready), 0);
      step();
    end
    vote_valid = 1'b0;
    vote_voter = 'x;
    vote_cand  = 'x;
    wait_done();

    step();
    step();
    check("results_drained", res_q.size(), 0);
    check("dups_drained",    dup_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
